// File: rtl/microsequencer.sv
// Purpose : next-state address generator for the microprogrammed control unit; picks
//           increment / jump / decode / branch / call / return / wait-on-MOC each cycle.
// Latency : 1 cycle from microword fields to the registered o_next_state.
// Backpressure: none; WAIT mode holds the address until i_moc or the MOC timeout.
//
// Ports:
//   i_clk            rising-edge clock
//   i_reset          asynchronous, active-high reset
//   i_ns_mode  [2:0] sequencing mode (0 INC,1 JMP,2 DEC,3 BRT,4 BRF,5 CALL,6 RET,7 WAIT)
//   i_cr_addr  [9:0] branch/jump/call target
//   i_cond_sel [1:0] picks the condition bit out of i_cond_in
//   i_cond_in  [3:0] condition bits {V,C,N,Z}
//   i_decoded_state [9:0] entry state from the instruction encoder
//   i_moc            memory operation complete
//   o_next_state [9:0] registered microstore address
//   o_bus_error      sticky, set on MOC timeout
//   o_stack_err      sticky, set on return-stack overflow/underflow
//
// Optional feature: define USTACK_EN for a STACK_DEPTH-entry return stack. Without it,
// CALL acts as JMP, RET jumps to 0 and o_stack_err is tied low.

module microsequencer #(
  parameter int unsigned NUM_STATES  = 256,
  parameter logic [9:0]  TRAP_STATE  = 10'd5,
  parameter int unsigned MOC_TIMEOUT = 255,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [2:0] i_ns_mode,
  input  logic [9:0] i_cr_addr,
  input  logic [1:0] i_cond_sel,
  input  logic [3:0] i_cond_in,
  input  logic [9:0] i_decoded_state,
  input  logic       i_moc,
  output logic [9:0] o_next_state,
  output logic       o_bus_error,
  output logic       o_stack_err
);

  typedef enum logic [2:0] {
    M_INC  = 3'd0,
    M_JMP  = 3'd1,
    M_DEC  = 3'd2,
    M_BRT  = 3'd3,
    M_BRF  = 3'd4,
    M_CALL = 3'd5,
    M_RET  = 3'd6,
    M_WAIT = 3'd7
  } mode_t;

  localparam logic [9:0] LAST_STATE = 10'(NUM_STATES - 1);
  // Counter value seen on the last allowed held cycle.
  localparam logic [9:0] WAIT_LAST  = 10'(MOC_TIMEOUT - 1);

  logic [9:0] r_next_state;
  logic       r_bus_error;
  logic [9:0] r_wait_cnt;

  mode_t      w_mode;
  logic [9:0] w_inc;
  logic       w_cond;
  logic       w_timeout;
  logic [9:0] w_next_state;
  logic [9:0] w_wait_cnt_nxt;
  logic       w_bus_error_nxt;

`ifdef USTACK_EN
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [9:0]      r_stack [STACK_DEPTH];
  logic [SP_W-1:0] r_sp;
  logic            r_stack_err;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_stack_fault;
  logic [IDX_W-1:0] w_top_idx;
  logic [IDX_W-1:0] w_push_idx;

  assign w_full     = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_top_idx  = IDX_W'(r_sp - 1'b1);
  assign w_push_idx = IDX_W'(r_sp);
`endif

  assign w_mode = mode_t'(i_ns_mode);
  // Wrap at the top of the microstore; addresses above it simply count on (10-bit).
  assign w_inc  = (r_next_state == LAST_STATE) ? 10'd0 : r_next_state + 10'd1;
  assign w_cond = i_cond_in[i_cond_sel];
  assign w_timeout = (r_wait_cnt == WAIT_LAST);

  always_comb begin
    w_next_state    = w_inc;
    w_wait_cnt_nxt  = 10'd0;
    w_bus_error_nxt = r_bus_error;
`ifdef USTACK_EN
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_stack_fault = 1'b0;
`endif
    case (w_mode)
      M_INC: w_next_state = w_inc;
      M_JMP: w_next_state = i_cr_addr;
      M_DEC: w_next_state = i_decoded_state;
      M_BRT: w_next_state = w_cond ? i_cr_addr : w_inc;
      M_BRF: w_next_state = w_cond ? w_inc : i_cr_addr;
      M_CALL: begin
        // The jump is taken even when the return address cannot be saved.
        w_next_state = i_cr_addr;
`ifdef USTACK_EN
        if (w_full) w_stack_fault = 1'b1;
        else        w_push        = 1'b1;
`endif
      end
      M_RET: begin
`ifdef USTACK_EN
        if (w_empty) begin
          w_next_state  = 10'd0;
          w_stack_fault = 1'b1;
        end else begin
          w_next_state = r_stack[w_top_idx];
          w_pop        = 1'b1;
        end
`else
        w_next_state = 10'd0;
`endif
      end
      M_WAIT: begin
        // moc takes priority over a timeout landing in the same cycle.
        if (i_moc) begin
          w_next_state = w_inc;
        end else if (w_timeout) begin
          w_next_state    = TRAP_STATE;
          w_bus_error_nxt = 1'b1;
        end else begin
          w_next_state   = r_next_state;
          w_wait_cnt_nxt = r_wait_cnt + 10'd1;
        end
      end
      default: w_next_state = w_inc;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_next_state <= 10'd0;
      r_bus_error  <= 1'b0;
      r_wait_cnt   <= 10'd0;
    end else begin
      r_next_state <= w_next_state;
      r_bus_error  <= w_bus_error_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
    end
  end

`ifdef USTACK_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sp        <= '0;
      r_stack_err <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) r_stack[i] <= 10'd0;
    end else begin
      if (w_push) begin
        r_stack[w_push_idx] <= w_inc;
        r_sp                <= r_sp + 1'b1;
      end else if (w_pop) begin
        r_sp <= r_sp - 1'b1;
      end
      if (w_stack_fault) r_stack_err <= 1'b1;
    end
  end

  assign o_stack_err = r_stack_err;
`else
  assign o_stack_err = 1'b0;
`endif

  assign o_next_state = r_next_state;
  assign o_bus_error  = r_bus_error;

endmodule

// File: tb/tb_microsequencer.sv
module tb_microsequencer;

  localparam int NS    = 256;
  localparam int TRAP  = 5;
  localparam int TO    = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic [2:0] ns_mode;
  logic [9:0] cr_addr;
  logic [1:0] cond_sel;
  logic [3:0] cond_in;
  logic [9:0] decoded_state;
  logic       moc;
  logic [9:0] next_state;
  logic       bus_error;
  logic       stack_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_ns;
  bit m_be;
  bit m_se;
  int m_waited;
  int m_stk[$];

  microsequencer #(
    .NUM_STATES (NS),
    .TRAP_STATE (10'd5),
    .MOC_TIMEOUT(TO),
    .STACK_DEPTH(DEPTH)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_ns_mode      (ns_mode),
    .i_cr_addr      (cr_addr),
    .i_cond_sel     (cond_sel),
    .i_cond_in      (cond_in),
    .i_decoded_state(decoded_state),
    .i_moc          (moc),
    .o_next_state   (next_state),
    .o_bus_error    (bus_error),
    .o_stack_err    (stack_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void model_reset();
    m_ns = 0; m_be = 0; m_se = 0; m_waited = 0;
    m_stk.delete();
  endfunction

  // Drive one microword, advance the model by the microsequencing rules, and step one clock.
  task automatic apply(input int mode, input int cr, input int sel, input int cin,
                       input int dec, input bit mc);
    int inc, nxt;
    bit cond;
    ns_mode = 3'(mode); cr_addr = 10'(cr); cond_sel = 2'(sel);
    cond_in = 4'(cin); decoded_state = 10'(dec); moc = mc;
    inc  = (m_ns == NS - 1) ? 0 : (m_ns + 1) % 1024;
    cond = ((cin >> sel) & 1) != 0;
    nxt  = inc;
    if (mode != 7) m_waited = 0;
    case (mode)
      1: nxt = cr;
      2: nxt = dec;
      3: nxt = cond ? cr : inc;
      4: nxt = cond ? inc : cr;
      5: begin
        nxt = cr;
`ifdef USTACK_EN
        if (m_stk.size() < DEPTH) m_stk.push_back(inc);
        else m_se = 1;
`endif
      end
      6: begin
`ifdef USTACK_EN
        if (m_stk.size() == 0) begin nxt = 0; m_se = 1; end
        else nxt = m_stk.pop_back();
`else
        nxt = 0;
`endif
      end
      7: begin
        if (mc) begin
          nxt = inc; m_waited = 0;
        end else begin
          m_waited++;
          if (m_waited == TO) begin nxt = TRAP; m_be = 1; m_waited = 0; end
          else nxt = m_ns;
        end
      end
      default: nxt = inc;
    endcase
    m_ns = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    checks++;
    if (next_state !== 10'd0 || bus_error !== 1'b0 || stack_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ns=%0d be=%b se=%b, want 0 0 0", next_state, bus_error, stack_err);
    end
    do_reset();
    apply(0, 0, 0, 0, 0, 0);
    checks++;
    if (next_state !== 10'd1) begin
      errors++;
      $display("FAIL reset_first_inc: ns=%0d, want 1", next_state);
    end
    apply(1, 2, 0, 0, 0, 0);
    for (int i = 0; i < TO; i++) apply(7, 0, 0, 0, 0, 0);
    apply(1, 42, 0, 0, 0, 0);
    checks++;
    if (next_state !== 10'd42 || bus_error !== 1'b1) begin
      errors++;
      $display("FAIL reset_setup: ns=%0d be=%b, want 42 1", next_state, bus_error);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (next_state !== 10'd0 || bus_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: ns=%0d be=%b, want 0 0", next_state, bus_error);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_inc();
    do_reset();
    apply(1, 3, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    checks++;
    if (next_state !== 10'd4) begin
      errors++;
      $display("FAIL inc_3: ns=%0d, want 4", next_state);
    end
    apply(1, 255, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    checks++;
    if (next_state !== 10'd0) begin
      errors++;
      $display("FAIL inc_wrap: ns=%0d, want 0", next_state);
    end
    apply(1, 300, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    checks++;
    if (next_state !== 10'd301) begin
      errors++;
      $display("FAIL inc_above_top: ns=%0d, want 301", next_state);
    end
  endtask

  task automatic test_branch();
    do_reset();
    apply(1, 7, 0, 0, 0, 0);
    apply(3, 20, 0, 4'b0001, 0, 0);
    checks++;
    if (next_state !== 10'd20) begin
      errors++;
      $display("FAIL brt_taken: ns=%0d, want 20", next_state);
    end
    apply(4, 20, 0, 4'b0001, 0, 0);
    checks++;
    if (next_state !== 10'd21) begin
      errors++;
      $display("FAIL brf_not_taken: ns=%0d, want 21", next_state);
    end
    apply(3, 90, 1, 4'b0001, 0, 0);
    checks++;
    if (next_state !== 10'd22) begin
      errors++;
      $display("FAIL brt_not_taken: ns=%0d, want 22", next_state);
    end
    apply(4, 90, 3, 4'b0111, 0, 0);
    checks++;
    if (next_state !== 10'd90) begin
      errors++;
      $display("FAIL brf_taken: ns=%0d, want 90", next_state);
    end
    apply(2, 0, 0, 0, 66, 0);
    checks++;
    if (next_state !== 10'd66) begin
      errors++;
      $display("FAIL decode: ns=%0d, want 66", next_state);
    end
  endtask

  task automatic test_wait();
    do_reset();
    apply(1, 2, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(7, 0, 0, 0, 0, 0);
      checks++;
      if (next_state !== 10'd2 || bus_error !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold%0d: ns=%0d be=%b, want 2 0", i, next_state, bus_error);
      end
    end
    apply(7, 0, 0, 0, 0, 1);
    checks++;
    if (next_state !== 10'd3 || bus_error !== 1'b0) begin
      errors++;
      $display("FAIL wait_moc: ns=%0d be=%b, want 3 0", next_state, bus_error);
    end
    apply(1, 2, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) apply(7, 0, 0, 0, 0, 0);
    checks++;
    if (next_state !== 10'd2 || bus_error !== 1'b0) begin
      errors++;
      $display("FAIL wait_pre_timeout: ns=%0d be=%b, want 2 0", next_state, bus_error);
    end
    apply(7, 0, 0, 0, 0, 0);
    checks++;
    if (next_state !== 10'd5 || bus_error !== 1'b1) begin
      errors++;
      $display("FAIL wait_timeout: ns=%0d be=%b, want 5 1", next_state, bus_error);
    end
    do_reset();
    apply(1, 2, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) apply(7, 0, 0, 0, 0, 0);
    apply(7, 0, 0, 0, 0, 1);
    checks++;
    if (next_state !== 10'd3 || bus_error !== 1'b0) begin
      errors++;
      $display("FAIL wait_moc_wins: ns=%0d be=%b, want 3 0", next_state, bus_error);
    end
    // A non-WAIT cycle in between restarts the held-cycle count.
    apply(1, 2, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) apply(7, 0, 0, 0, 0, 0);
    apply(1, 2, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) apply(7, 0, 0, 0, 0, 0);
    checks++;
    if (next_state !== 10'd2 || bus_error !== 1'b0) begin
      errors++;
      $display("FAIL wait_count_clear: ns=%0d be=%b, want 2 0", next_state, bus_error);
    end
  endtask

  task automatic test_stack();
    int exp_ret[4];
    do_reset();
    apply(1, 10, 0, 0, 0, 0);
    apply(5, 50, 0, 0, 0, 0);
    checks++;
    if (next_state !== 10'd50) begin
      errors++;
      $display("FAIL call_jump: ns=%0d, want 50", next_state);
    end
    apply(6, 0, 0, 0, 0, 0);
`ifdef USTACK_EN
    checks++;
    if (next_state !== 10'd11 || stack_err !== 1'b0) begin
      errors++;
      $display("FAIL ret_pop: ns=%0d se=%b, want 11 0", next_state, stack_err);
    end
    apply(1, 10, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(5, 100 + i, 0, 0, 0, 0);
      checks++;
      if (next_state !== 10'(100 + i) || stack_err !== (i == 4)) begin
        errors++;
        $display("FAIL call_nest%0d: ns=%0d se=%b, want %0d %0d", i, next_state, stack_err,
                 100 + i, i == 4);
      end
    end
    exp_ret = '{103, 102, 101, 11};
    for (int i = 0; i < 4; i++) begin
      apply(6, 0, 0, 0, 0, 0);
      checks++;
      if (next_state !== 10'(exp_ret[i])) begin
        errors++;
        $display("FAIL ret_nest%0d: ns=%0d, want %0d", i, next_state, exp_ret[i]);
      end
    end
    do_reset();
    apply(1, 30, 0, 0, 0, 0);
    apply(6, 0, 0, 0, 0, 0);
    checks++;
    if (next_state !== 10'd0 || stack_err !== 1'b1) begin
      errors++;
      $display("FAIL ret_empty: ns=%0d se=%b, want 0 1", next_state, stack_err);
    end
`else
    exp_ret = '{0, 0, 0, 0};
    checks++;
    if (next_state !== 10'(exp_ret[0]) || stack_err !== 1'b0) begin
      errors++;
      $display("FAIL ret_nostack: ns=%0d se=%b, want 0 0", next_state, stack_err);
    end
    for (int i = 0; i < 6; i++) apply(5, 200 + i, 0, 0, 0, 0);
    checks++;
    if (next_state !== 10'd205 || stack_err !== 1'b0) begin
      errors++;
      $display("FAIL call_nostack: ns=%0d se=%b, want 205 0", next_state, stack_err);
    end
`endif
  endtask

  task automatic test_random();
    int mode;
    int bad = 0;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      mode = ($urandom_range(0, 3) == 0) ? 7 : int'($urandom_range(0, 7));
      apply(mode,
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 255)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 1023)), $urandom_range(0, 2) == 0);
      checks++;
      if (next_state !== 10'(m_ns) || bus_error !== m_be || stack_err !== m_se) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d] mode=%0d: ns=%0d be=%b se=%b, want ns=%0d be=%0d se=%0d",
                   n, mode, next_state, bus_error, stack_err, m_ns, m_be, m_se);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ns_mode = 3'd0; cr_addr = 10'd0; cond_sel = 2'd0; cond_in = 4'd0;
    decoded_state = 10'd0; moc = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_inc();
    test_branch();
    test_wait();
    test_stack();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
